wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port in_valid  input  1  MEM stage presents an instruction this cycle.
REQ-004 SHALL have port in_ready  output  1  stage accepts; equals !hold.
REQ-005 SHALL have port hold  input  1  freeze stage register; no capture, no retire.
REQ-006 SHALL have port flush  input  1  discard instruction captured this cycle.
REQ-007 SHALL have port mem_regwrite  input  1  instruction writes a register.
REQ-008 SHALL have port mem_memtoreg  input  1  result from load data (1) or ALU (0).
REQ-009 SHALL have port mem_load_type  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU.
REQ-010 SHALL have port mem_waddr  input  5  destination register.
REQ-011 SHALL have port mem_alu_result  input  32  ALU result / load address.
REQ-012 SHALL have port mem_rdata  input  32  aligned word read from data memory.
REQ-013 SHALL have port w_enable  output  1  register-file write enable.
REQ-014 SHALL have port w_addr1  output  5  register-file write address.
REQ-015 SHALL have port w_data1  output  32  register-file write data; also forwarding source.
REQ-016 SHALL have port wb_valid  output  1  stage register holds a live instruction.
REQ-017 SHALL have port align_err  output  1  sticky misaligned-halfword flag.
REQ-018 SHALL have port retire_cnt  output  32  count of retired instructions.

Function
REQ-019 SHALL capture inputs at rising clk when in_valid & !hold & !flush; wb_valid<=1.
REQ-020 SHALL set wb_valid<=0 at rising clk when !hold and (!in_valid or flush).
REQ-021 SHALL keep all stage state unchanged while hold=1 and flush=0.
REQ-022 SHALL give flush priority over hold: flush=1 clears wb_valid regardless of hold.
REQ-023 SHALL compute w_data1 in the capture cycle and register it: one-cycle latency, outputs stable from rising edge so the register file's falling-edge write sees settled values.
REQ-024 SHALL drive w_enable = wb_valid & regwrite_q & (w_addr1!=0) & !misaligned_q.
REQ-025 SHALL select w_data1 = alu_result when memtoreg=0, else load-extracted mem_rdata.
REQ-026 SHALL use big-endian lanes, offset = mem_alu_result[1:0]: byte 0 = bits 31:24, byte 3 = bits 7:0; half offset[1]=0 = bits 31:16, offset[1]=1 = bits 15:0.
REQ-027 SHALL sign-extend LB/LH and zero-extend LBU/LHU to 32 bits; LW passes word unchanged, offset ignored.
REQ-028 SHALL treat LH/LHU with offset[0]=1 as misaligned: w_enable suppressed, align_err set at capture and held until reset.
REQ-029 SHALL treat load_type 101-111 as LW.
REQ-030 SHALL increment retire_cnt by 1 at each rising clk where wb_valid=1 and hold=0; wraps 0xFFFFFFFF->0.
REQ-031 SHALL count misaligned and regwrite=0 instructions as retired.

Reset
REQ-032 SHALL on rst_n=0 immediately clear wb_valid, w_enable, w_addr1, w_data1, align_err, retire_cnt to 0.
REQ-033 SHALL discard any captured instruction on reset mid-operation; first capture allowed at first rising clk with rst_n=1.

Configuration
REQ-034 SHALL, with WB_SUBWORD_EN defined, implement REQ-026..REQ-029 fully.
REQ-035 SHALL, without WB_SUBWORD_EN, treat every load as LW, ignore mem_load_type, and tie align_err to 0.

Verification
REQ-036 SHALL test ALU write: regwrite=1, waddr=5, alu=0x12345678 -> next cycle w_enable=1, w_addr1=5, w_data1=0x12345678, retire_cnt=1.
REQ-037 SHALL test LB: rdata=0x80FF7F01, alu[1:0]=00 -> w_data1=0xFFFFFF80; LBU offset 01 -> 0x000000FF.
REQ-038 SHALL test LH offset 11 -> w_enable=0, align_err=1, stays 1 after later valid loads.
REQ-039 SHALL test waddr=0, regwrite=1 -> w_enable=0, retire_cnt increments.
REQ-040 SHALL test hold=1 for 3 cycles with new inputs -> outputs unchanged, retire_cnt frozen; flush with hold -> wb_valid=0.
REQ-041 SHALL test rst_n low mid-stream -> all outputs 0 asynchronously; retire_cnt preset 0xFFFFFFFF wraps to 0 on next retire.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM->WB pipeline bus: instruction fields, handshake and stage control.
interface wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        hold;
  logic        flush;
  logic        mem_regwrite;
  logic        mem_memtoreg;
  logic [2:0]  mem_load_type;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rdata;

  modport master (
    output in_valid, hold, flush, mem_regwrite, mem_memtoreg,
           mem_load_type, mem_waddr, mem_alu_result, mem_rdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, hold, flush, mem_regwrite, mem_memtoreg,
           mem_load_type, mem_waddr, mem_alu_result, mem_rdata,
    output in_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage register with load extraction and retire counter.
// Sub-word loads (LB/LBU/LH/LHU, misalignment flag) are built only with WB_SUBWORD_EN.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  wb_stage_if.slave   mem,
  output logic        w_enable,
  output logic [4:0]  w_addr1,
  output logic [31:0] w_data1,
  output logic        wb_valid,
  output logic        align_err,
  output logic [31:0] retire_cnt
);

  logic        regwrite_q;
  logic        misaligned_q;
  logic        capture;
  logic        misaligned_d;
  logic [31:0] wdata_d;

  assign mem.in_ready = !mem.hold;
  assign capture      = mem.in_valid & !mem.hold & !mem.flush;

`ifdef WB_SUBWORD_EN
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } load_e;

  logic [1:0]  offset;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic        load_mis;

  assign offset = mem.mem_alu_result[1:0];

  // Big-endian lanes: offset 0 selects the most significant byte/half.
  always_comb begin
    lane_b = '0;
    case (offset)
      2'd0:    lane_b = mem.mem_rdata[31:24];
      2'd1:    lane_b = mem.mem_rdata[23:16];
      2'd2:    lane_b = mem.mem_rdata[15:8];
      default: lane_b = mem.mem_rdata[7:0];
    endcase
    lane_h = offset[1] ? mem.mem_rdata[15:0] : mem.mem_rdata[31:16];
  end

  always_comb begin
    load_val = mem.mem_rdata;
    load_mis = 1'b0;
    case (mem.mem_load_type)
      LD_B:    load_val = {{24{lane_b[7]}}, lane_b};
      LD_BU:   load_val = {24'd0, lane_b};
      LD_H: begin
        load_val = {{16{lane_h[15]}}, lane_h};
        load_mis = offset[0];
      end
      LD_HU: begin
        load_val = {16'd0, lane_h};
        load_mis = offset[0];
      end
      default: load_val = mem.mem_rdata;
    endcase
    wdata_d      = mem.mem_memtoreg ? load_val : mem.mem_alu_result;
    misaligned_d = mem.mem_memtoreg & load_mis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err <= 1'b0;
    end else if (capture && misaligned_d) begin
      align_err <= 1'b1;
    end
  end
`else
  logic unused_load_type;
  assign unused_load_type = ^mem.mem_load_type;
  assign wdata_d          = mem.mem_memtoreg ? mem.mem_rdata : mem.mem_alu_result;
  assign misaligned_d     = 1'b0;
  assign align_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      regwrite_q   <= 1'b0;
      misaligned_q <= 1'b0;
      w_addr1      <= '0;
      w_data1      <= '0;
      retire_cnt   <= '0;
    end else begin
      if (wb_valid && !mem.hold) begin
        retire_cnt <= retire_cnt + 32'd1;
      end
      // Flush wins over hold; otherwise hold freezes everything.
      if (mem.flush) begin
        wb_valid <= 1'b0;
      end else if (!mem.hold) begin
        wb_valid <= mem.in_valid;
        if (mem.in_valid) begin
          regwrite_q   <= mem.mem_regwrite;
          misaligned_q <= misaligned_d;
          w_addr1      <= mem.mem_waddr;
          w_data1      <= wdata_d;
        end
      end
    end
  end

  assign w_enable = wb_valid & regwrite_q & (w_addr1 != '0) & !misaligned_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed steps plus random traffic against a behavioural model.
module tb_wb_stage;
  logic        clk;
  logic        rst_n;
  logic        w_enable;
  logic [4:0]  w_addr1;
  logic [31:0] w_data1;
  logic        wb_valid;
  logic        align_err;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  // Model state
  logic        m_valid, m_rw, m_mis, m_err;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_cnt;

  wb_stage_if bus ();

  wb_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (bus.slave),
    .w_enable   (w_enable),
    .w_addr1    (w_addr1),
    .w_data1    (w_data1),
    .wb_valid   (wb_valid),
    .align_err  (align_err),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref_data(input logic m2r, input logic [2:0] lt,
                                           input logic [31:0] alu, input logic [31:0] rdata);
`ifdef WB_SUBWORD_EN
    int unsigned off;
    int unsigned b;
    int unsigned h;
    off = int'(alu & 32'd3);
    b = (rdata >> (8 * (3 - off))) & 32'hFF;
    h = (rdata >> (16 * (1 - off / 2))) & 32'hFFFF;
`endif
    if (!m2r) return alu;
`ifdef WB_SUBWORD_EN
    case (lt)
      3'd1: return 32'(b >= 128 ? int'(b) - 256 : int'(b));
      3'd2: return 32'(b);
      3'd3: return 32'(h >= 32768 ? int'(h) - 65536 : int'(h));
      3'd4: return 32'(h);
      default: return rdata;
    endcase
`else
    return rdata;
`endif
  endfunction

  function automatic logic ref_mis(input logic m2r, input logic [2:0] lt, input logic [31:0] alu);
`ifdef WB_SUBWORD_EN
    return m2r && (lt == 3'd3 || lt == 3'd4) && (alu % 2 == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mis = 0; m_err = 0;
    m_addr = '0; m_data = '0; m_cnt = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    if (m_valid && !bus.hold) m_cnt = m_cnt + 1;
    if (bus.flush) m_valid = 0;
    else if (!bus.hold) begin
      m_valid = bus.in_valid;
      if (bus.in_valid) begin
        m_rw   = bus.mem_regwrite;
        m_addr = bus.mem_waddr;
        m_data = ref_data(bus.mem_memtoreg, bus.mem_load_type, bus.mem_alu_result, bus.mem_rdata);
        m_mis  = ref_mis(bus.mem_memtoreg, bus.mem_load_type, bus.mem_alu_result);
        if (m_mis) m_err = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_we;
    exp_we = m_valid && m_rw && (m_addr != 0) && !m_mis;
    chk({tag, ":wb_valid"},   32'(wb_valid),  32'(m_valid));
    chk({tag, ":w_enable"},   32'(w_enable),  32'(exp_we));
    chk({tag, ":w_addr1"},    32'(w_addr1),   32'(m_addr));
    chk({tag, ":w_data1"},    w_data1,        m_data);
    chk({tag, ":align_err"},  32'(align_err), 32'(m_err));
    chk({tag, ":retire_cnt"}, retire_cnt,     m_cnt);
    chk({tag, ":in_ready"},   32'(bus.in_ready), 32'(!bus.hold));
  endtask

  task automatic drive(input logic v, input logic h, input logic f, input logic rw,
                       input logic m2r, input logic [2:0] lt, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [31:0] rd);
    @(negedge clk);
    bus.in_valid = v; bus.hold = h; bus.flush = f;
    bus.mem_regwrite = rw; bus.mem_memtoreg = m2r; bus.mem_load_type = lt;
    bus.mem_waddr = wa; bus.mem_alu_result = alu; bus.mem_rdata = rd;
  endtask

  task automatic edge_check(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic step(input string tag, input logic v, input logic h, input logic f,
                      input logic rw, input logic m2r, input logic [2:0] lt, input logic [4:0] wa,
                      input logic [31:0] alu, input logic [31:0] rd);
    drive(v, h, f, rw, m2r, lt, wa, alu, rd);
    edge_check(tag);
  endtask

  initial begin
    logic v, h, f, rw, m2r;
    logic [2:0] lt;

    rst_n = 1'b0;
    bus.in_valid = 0; bus.hold = 0; bus.flush = 0; bus.mem_regwrite = 0;
    bus.mem_memtoreg = 0; bus.mem_load_type = '0; bus.mem_waddr = '0;
    bus.mem_alu_result = '0; bus.mem_rdata = '0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("alu_wr", 1, 0, 0, 1, 0, 3'd0, 5'd5, 32'h12345678, 32'hDEADBEEF);
    chk("alu_wr_data", w_data1, 32'h12345678);
    chk("alu_wr_en", 32'(w_enable), 32'd1);
    step("lb", 1, 0, 0, 1, 1, 3'd1, 5'd7, 32'h00000100, 32'h80FF7F01);
    chk("alu_wr_retire", retire_cnt, 32'd1);
`ifdef WB_SUBWORD_EN
    chk("lb_data", w_data1, 32'hFFFFFF80);
`endif
    step("lbu", 1, 0, 0, 1, 1, 3'd2, 5'd8, 32'h00000101, 32'h80FF7F01);
`ifdef WB_SUBWORD_EN
    chk("lbu_data", w_data1, 32'h000000FF);
`endif
    step("lh_mis", 1, 0, 0, 1, 1, 3'd3, 5'd9, 32'h00000103, 32'h80FF7F01);
    step("lw_after", 1, 0, 0, 1, 1, 3'd0, 5'd10, 32'h00000200, 32'hCAFEF00D);
    step("lhu_ok", 1, 0, 0, 1, 1, 3'd4, 5'd11, 32'h00000202, 32'h1234ABCD);
    step("lt_hi", 1, 0, 0, 1, 1, 3'd6, 5'd12, 32'h00000203, 32'h89ABCDEF);
    step("x0_wr", 1, 0, 0, 1, 0, 3'd0, 5'd0, 32'h55555555, 32'h0);
    chk("x0_wr_en", 32'(w_enable), 32'd0);
    step("bubble", 0, 0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0);
    step("cap", 1, 0, 0, 1, 0, 3'd0, 5'd9, 32'hAAAA5555, 32'h0);
    for (int i = 0; i < 3; i++)
      step("hold", 1, 1, 0, 1, 1, 3'd1, 5'(i + 20), $urandom, $urandom);
    step("hold_flush", 1, 1, 1, 1, 0, 3'd0, 5'd3, 32'h1, 32'h0);
    chk("hold_flush_valid", 32'(wb_valid), 32'd0);
    step("after_flush", 1, 0, 0, 1, 0, 3'd0, 5'd4, 32'h2, 32'h0);
    step("flush_only", 1, 0, 1, 1, 0, 3'd0, 5'd6, 32'h3, 32'h0);

    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      h   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 7) == 0);
      rw  = ($urandom_range(0, 4) != 0);
      m2r = $urandom_range(0, 1);
      lt  = m2r ? 3'($urandom_range(0, 7)) : 3'd0;
      step("rand", v, h, f, rw, m2r, lt, 5'($urandom_range(0, 31)), $urandom, $urandom);
    end

    // Counter wrap: preload all-ones, then retire one instruction.
    step("pre_wrap", 1, 0, 0, 1, 0, 3'd0, 5'd1, 32'h77, 32'h0);
    drive(0, 0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0);
    force dut.retire_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt;
    m_cnt = 32'hFFFFFFFF;
    edge_check("wrap");
    chk("wrap_zero", retire_cnt, 32'd0);

    step("pre_rst", 1, 0, 0, 1, 1, 3'd3, 5'd2, 32'h00000001, 32'h12345678);
    step("pre_rst2", 1, 0, 0, 1, 0, 3'd0, 5'd3, 32'h9, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    step("in_rst", 1, 0, 0, 1, 0, 3'd0, 5'd4, 32'hABCD, 32'h0);
    drive(1, 0, 0, 1, 0, 3'd0, 5'd13, 32'h13131313, 32'h0);
    rst_n = 1'b1;
    edge_check("first_cap");
    step("post_rst", 0, 0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
